// File: rtl/strip_check_crc.sv
// RX FCS handler: checks CRC-32 over each frame including its FCS, strips the 4 FCS bytes,
// and flags bad or upstream-errored frames on the last payload beat via tuser.
module strip_check_crc #(
    parameter int DATA_BYTES = 8,
    parameter int DATA_BITS  = DATA_BYTES * 8
) (
    input  logic                  clock,
    input  logic                  aresetn,
    input  logic [DATA_BITS-1:0]  saxis_tdata,
    input  logic                  saxis_tvalid,
    output logic                  saxis_tready,
    input  logic [DATA_BYTES-1:0] saxis_tkeep,
    input  logic                  saxis_tlast,
    input  logic                  saxis_tuser,
    output logic [DATA_BITS-1:0]  maxis_tdata,
    output logic                  maxis_tvalid,
    input  logic                  maxis_tready,
    output logic [DATA_BYTES-1:0] maxis_tkeep,
    output logic                  maxis_tlast,
    output logic                  maxis_tuser,
    output logic                  crc_err_pulse,
    output logic                  runt_drop_pulse
);

    localparam int                    NB          = $clog2(DATA_BYTES + 1);
    localparam logic [31:0]           CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]           CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]           CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [DATA_BYTES-1:0] KEEP_ALL    = '1;
    localparam logic [DATA_BYTES-1:0] KEEP_LO4    = DATA_BYTES'(15);

    // How the accepted input beat relates to the held beat and the FCS position.
    typedef enum logic [2:0] {
        BEAT_FIRST,    // non-last, nothing held yet
        BEAT_MID,      // non-last, held beat goes out
        LAST_SPLIT,    // n>4 with held beat: held out now, tail payload via pending
        LAST_ALIGNED,  // n==4 with held beat: held beat is the last payload beat
        LAST_SHORT,    // n<4 with held beat: FCS starts inside held beat
        LAST_SINGLE,   // single-beat frame with payload
        LAST_RUNT      // single-beat frame of FCS only
    } beat_class_e;

    // NOTE: blocking '=' inside functions is correct: it builds a combinational chain, not state.
    function automatic logic [31:0] crc_beat(input logic [31:0]           crc_in,
                                             input logic [DATA_BITS-1:0]  data,
                                             input logic [DATA_BYTES-1:0] keep);
        logic [31:0] c;
        c = crc_in;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (keep[b]) begin
                c = c ^ {24'd0, data[8*b +: 8]};
                for (int k = 0; k < 8; k++)
                    c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic logic [DATA_BITS-1:0] mask_bytes(input logic [DATA_BITS-1:0]  data,
                                                        input logic [DATA_BYTES-1:0] keep);
        logic [DATA_BITS-1:0] m;
        for (int b = 0; b < DATA_BYTES; b++)
            m[8*b +: 8] = keep[b] ? data[8*b +: 8] : 8'd0;
        return m;
    endfunction

    logic [31:0]           r_crc;
    logic [DATA_BITS-1:0]  r_held_data;
    logic                  r_held_valid;
    logic                  r_user_acc;
    logic [DATA_BITS-1:0]  r_pend_data;
    logic [DATA_BYTES-1:0] r_pend_keep;
    logic                  r_pend_user;
    logic                  r_pend_valid;
    logic [DATA_BITS-1:0]  r_m_tdata;
    logic [DATA_BYTES-1:0] r_m_tkeep;
    logic                  r_m_tlast;
    logic                  r_m_tuser;
    logic                  r_m_tvalid;
    logic                  r_crc_err_pulse;
    logic                  r_runt_pulse;

    logic                  w_out_free;
    logic                  w_accept;
    logic [31:0]           w_crc_next;
    logic                  w_crc_bad;
    logic                  w_frame_err;
    logic [NB-1:0]         w_n;
    beat_class_e           w_class;
    logic [DATA_BYTES-1:0] w_tail_keep;
    logic [DATA_BYTES-1:0] w_short_keep;
    logic                  w_ld;
    logic [DATA_BITS-1:0]  w_ld_data;
    logic [DATA_BYTES-1:0] w_ld_keep;
    logic                  w_ld_last;
    logic                  w_ld_user;

    assign w_out_free   = !r_m_tvalid || maxis_tready;
    assign saxis_tready = !r_pend_valid && w_out_free;
    assign w_accept     = saxis_tvalid && saxis_tready;
    assign w_crc_next   = crc_beat(r_crc, saxis_tdata, saxis_tkeep);
    assign w_crc_bad    = (w_crc_next != CRC_RESIDUE);
    assign w_frame_err  = w_crc_bad || r_user_acc || saxis_tuser;
    // With contiguous keep, shifting the mask equals (1<<(n-4))-1 and (1<<(4+n))-1.
    assign w_tail_keep  = saxis_tkeep >> 4;
    assign w_short_keep = (saxis_tkeep << 4) | KEEP_LO4;

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        w_n     = '0;
        w_class = BEAT_FIRST;
        for (int b = 0; b < DATA_BYTES; b++)
            w_n = w_n + NB'(saxis_tkeep[b]);
        if (!saxis_tlast)
            w_class = r_held_valid ? BEAT_MID : BEAT_FIRST;
        else if (r_held_valid)
            w_class = (w_n > NB'(4)) ? LAST_SPLIT : (w_n == NB'(4)) ? LAST_ALIGNED : LAST_SHORT;
        else
            w_class = (w_n > NB'(4)) ? LAST_SINGLE : LAST_RUNT;
    end

    // Output register load: pending tail has priority; input is stalled while it exists.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_data = '0;
        w_ld_keep = '0;
        w_ld_last = 1'b0;
        w_ld_user = 1'b0;
        if (r_pend_valid && w_out_free) begin
            w_ld      = 1'b1;
            w_ld_data = r_pend_data;
            w_ld_keep = r_pend_keep;
            w_ld_last = 1'b1;
            w_ld_user = r_pend_user;
        end else if (w_accept) begin
            case (w_class)
                BEAT_MID, LAST_SPLIT: begin
                    w_ld      = 1'b1;
                    w_ld_data = r_held_data;
                    w_ld_keep = KEEP_ALL;
                end
                LAST_ALIGNED: begin
                    w_ld      = 1'b1;
                    w_ld_data = r_held_data;
                    w_ld_keep = KEEP_ALL;
                    w_ld_last = 1'b1;
                    w_ld_user = w_frame_err;
                end
                LAST_SHORT: begin
                    w_ld      = 1'b1;
                    w_ld_data = mask_bytes(r_held_data, w_short_keep);
                    w_ld_keep = w_short_keep;
                    w_ld_last = 1'b1;
                    w_ld_user = w_frame_err;
                end
                LAST_SINGLE: begin
                    w_ld      = 1'b1;
                    w_ld_data = mask_bytes(saxis_tdata, w_tail_keep);
                    w_ld_keep = w_tail_keep;
                    w_ld_last = 1'b1;
                    w_ld_user = w_frame_err;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: data registers are reset too, since every maxis_* output must read 0 out of reset.
        if (!aresetn) begin
            r_crc           <= CRC_INIT;
            r_held_data     <= '0;
            r_held_valid    <= 1'b0;
            r_user_acc      <= 1'b0;
            r_pend_data     <= '0;
            r_pend_keep     <= '0;
            r_pend_user     <= 1'b0;
            r_pend_valid    <= 1'b0;
            r_m_tdata       <= '0;
            r_m_tkeep       <= '0;
            r_m_tlast       <= 1'b0;
            r_m_tuser       <= 1'b0;
            r_m_tvalid      <= 1'b0;
            r_crc_err_pulse <= 1'b0;
            r_runt_pulse    <= 1'b0;
        end else begin
            r_crc_err_pulse <= 1'b0;
            r_runt_pulse    <= 1'b0;

            if (w_ld) begin
                r_m_tdata  <= w_ld_data;
                r_m_tkeep  <= w_ld_keep;
                r_m_tlast  <= w_ld_last;
                r_m_tuser  <= w_ld_user;
                r_m_tvalid <= 1'b1;
            end else if (maxis_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (r_pend_valid && w_out_free)
                r_pend_valid <= 1'b0;

            if (w_accept) begin
                if (!saxis_tlast) begin
                    r_crc        <= w_crc_next;
                    r_held_data  <= saxis_tdata;
                    r_held_valid <= 1'b1;
                    r_user_acc   <= r_user_acc | saxis_tuser;
                end else begin
                    r_crc           <= CRC_INIT;
                    r_held_valid    <= 1'b0;
                    r_user_acc      <= 1'b0;
                    r_crc_err_pulse <= w_crc_bad;
                    r_runt_pulse    <= (w_class == LAST_RUNT);
                    if (w_class == LAST_SPLIT) begin
                        r_pend_data  <= mask_bytes(saxis_tdata, w_tail_keep);
                        r_pend_keep  <= w_tail_keep;
                        r_pend_user  <= w_frame_err;
                        r_pend_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign maxis_tdata     = r_m_tdata;
    assign maxis_tkeep     = r_m_tkeep;
    assign maxis_tlast     = r_m_tlast;
    assign maxis_tuser     = r_m_tuser;
    assign maxis_tvalid    = r_m_tvalid;
    assign crc_err_pulse   = r_crc_err_pulse;
    assign runt_drop_pulse = r_runt_pulse;

endmodule
